// File: rtl/y86_pkg.sv
// y86_pkg: shared constants for the Y86-64 pipeline control slice.
//   - icode encodings, register "none" code, stage status codes
//   - ctrl_state: program-status state machine encoding used by pipe_ctrl
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] STAT_HLT = 4'h2;
    localparam logic [3:0] STAT_ADR = 4'h3;
    localparam logic [3:0] STAT_INS = 4'h4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state;

endpackage

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: purely combinational hazard terms for pipe_ctrl.
// Ports:
//   D_icode, d_srcA, d_srcB  - instruction in D and its decode sources
//   E_icode, E_dstM, e_Cnd   - instruction in E, its load destination, branch result
//   m_stat, W_stat           - memory / write-back stage status
//   lu                       - load/use hazard
//   mp                       - jXX mispredicted (taken predicted, not taken)
//   rt                       - ret sitting in D
//   ex                       - exception status in M or W
module pipe_hazard_detect
    import y86_pkg::*;
(
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] m_stat,
    input  logic [3:0] W_stat,
    output logic       lu,
    output logic       mp,
    output logic       rt,
    output logic       ex
);

    logic e_is_load;

    assign e_is_load = (E_icode == IMRMOVQ) || (E_icode == IPOPQ);
    // RNONE guard matters: a decode source of RNONE must never match a load with no destination.
    assign lu = e_is_load && (E_dstM != RNONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign mp = (E_icode == IJXX) && !e_Cnd;
    assign rt = (D_icode == IRET);
    assign ex = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Y86-64 five-stage pipeline control unit.
// Generates stall/bubble controls (combinational, zero latency) from hazard
// terms plus registered state: ret bubble counter and a sticky program-status
// FSM (RUN -> DRAIN -> HALTED) that drains and then freezes the pipeline.
// Optional macro PIPE_CTRL_PERF_EN adds saturating counters cyc_cnt,
// stall_cnt, bubble_cnt (CNT_W bits each).
// Ports:
//   clk, rst                       - clock, async active-high reset
//   D_icode, d_srcA, d_srcB        - D-stage instruction and sources
//   E_icode, E_dstM, e_Cnd         - E-stage instruction, load dest, branch cond
//   m_stat, W_stat                 - M / W stage status
//   F_stall, D_stall, W_stall      - register holds
//   D_bubble, E_bubble, M_bubble   - nop injection
//   set_cc                         - condition-code write enable
//   halted, prog_stat              - sticky frozen flag and final status
//
// state  | meaning
// RUN    | normal operation, hazard controls active
// DRAIN  | fault seen in M, let older instructions reach W, admit nothing new
// HALTED | faulting instruction reached W, pipeline frozen until reset
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int RET_BUBBLES = 3,
    parameter int CNT_W       = 32
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] m_stat,
    input  logic [3:0] W_stat,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble,
    output logic       M_bubble,
    output logic       W_stall,
    output logic       set_cc,
    output logic       halted,
    output logic [3:0] prog_stat
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    localparam logic [2:0] RET_LOAD = 3'(RET_BUBBLES - 1);

    ctrl_state  state;
    logic [2:0] ret_cnt;
    logic       lu, mp, rt, ex;
    logic       ret_busy;

    pipe_hazard_detect u_hazard (
        .D_icode (D_icode),
        .d_srcA  (d_srcA),
        .d_srcB  (d_srcB),
        .E_icode (E_icode),
        .E_dstM  (E_dstM),
        .e_Cnd   (e_Cnd),
        .m_stat  (m_stat),
        .W_stat  (W_stat),
        .lu      (lu),
        .mp      (mp),
        .rt      (rt),
        .ex      (ex)
    );

    assign ret_busy = (ret_cnt != 3'd0);
    assign halted   = (state == HALTED);

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        case (state)
            RUN: begin
                F_stall  = lu | rt | ret_busy;
                // mp wins over lu for D: the D instruction is on the wrong path anyway.
                D_stall  = lu & !mp;
                D_bubble = mp | (!lu & (rt | ret_busy));
                E_bubble = mp | lu;
                M_bubble = ex;
                W_stall  = (W_stat != STAT_AOK);
                set_cc   = (E_icode == IOPQ) & !ex;
            end
            DRAIN: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
            default: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ret_cnt   <= 3'd0;
            prog_stat <= STAT_AOK;
        end else begin
            case (state)
                RUN: begin
                    if (W_stat != STAT_AOK) begin
                        state     <= HALTED;
                        prog_stat <= W_stat;
                    end else if (m_stat != STAT_AOK) begin
                        state   <= DRAIN;
                        ret_cnt <= 3'd0;
                    end else if (rt && !lu && !mp && !ret_busy) begin
                        ret_cnt <= RET_LOAD;
                    end else if (ret_busy) begin
                        ret_cnt <= ret_cnt - 3'd1;
                    end
                end
                DRAIN: begin
                    if (W_stat != STAT_AOK) begin
                        state     <= HALTED;
                        prog_stat <= W_stat;
                    end else if (ret_busy) begin
                        ret_cnt <= ret_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt    <= '0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (!halted && (cyc_cnt != '1))
                cyc_cnt <= cyc_cnt + 1'b1;
            if (F_stall && !halted && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (E_bubble && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    import y86_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, m_stat, W_stat;
    logic       e_Cnd;
    logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [3:0] prog_stat;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] cyc_cnt, stall_cnt, bubble_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .D_icode   (D_icode),
        .d_srcA    (d_srcA),
        .d_srcB    (d_srcB),
        .E_icode   (E_icode),
        .E_dstM    (E_dstM),
        .e_Cnd     (e_Cnd),
        .m_stat    (m_stat),
        .W_stat    (W_stat),
        .F_stall   (F_stall),
        .D_stall   (D_stall),
        .D_bubble  (D_bubble),
        .E_bubble  (E_bubble),
        .M_bubble  (M_bubble),
        .W_stall   (W_stall),
        .set_cc    (set_cc),
        .halted    (halted),
        .prog_stat (prog_stat)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted}
    function automatic logic [7:0] outs();
        return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted};
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (F Ds Db Eb Mb Ws cc h)", name, act, exp);
        end
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_idle();
        D_icode = INOP;  d_srcA = RNONE; d_srcB = RNONE;
        E_icode = INOP;  E_dstM = RNONE; e_Cnd = 1'b1;
        m_stat = STAT_AOK; W_stat = STAT_AOK;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // settle at the next falling edge after inputs were driven
    task automatic next_cycle();
        @(negedge clk);
    endtask

    typedef struct {
        string      name;
        logic [3:0] d_icode, srca, srcb, e_icode, e_dstm;
        logic       cnd;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{"idle",        INOP,  RNONE, RNONE, INOP,    RNONE, 1'b1, 8'b0000_0000};
        vecs[1] = '{"lu_srcA",     IOPQ,  4'd3,  RNONE, IMRMOVQ, 4'd3,  1'b1, 8'b1101_0000};
        vecs[2] = '{"lu_popq_srcB",IOPQ,  RNONE, 4'd5,  IPOPQ,   4'd5,  1'b1, 8'b1101_0000};
        vecs[3] = '{"lu_rnone",    IOPQ,  RNONE, RNONE, IMRMOVQ, RNONE, 1'b1, 8'b0000_0000};
        vecs[4] = '{"lu_nomatch",  IOPQ,  4'd4,  4'd6,  IMRMOVQ, 4'd3,  1'b1, 8'b0000_0000};
        vecs[5] = '{"store_nolu",  IOPQ,  4'd3,  RNONE, IRMMOVQ, 4'd3,  1'b1, 8'b0000_0000};
        vecs[6] = '{"mispredict",  IOPQ,  RNONE, RNONE, IJXX,    RNONE, 1'b0, 8'b0011_0000};
        vecs[7] = '{"jxx_taken",   IOPQ,  RNONE, RNONE, IJXX,    RNONE, 1'b1, 8'b0000_0000};
        vecs[8] = '{"opq_setcc",   INOP,  RNONE, RNONE, IOPQ,    4'd2,  1'b1, 8'b0000_0010};
        vecs[9] = '{"lu_after",    IOPQ,  4'd3,  RNONE, IMRMOVQ, RNONE, 1'b1, 8'b0000_0000};

        rst = 1'b1;
        set_idle();
        #12;
        check8("reset_outs", outs(), 8'b0000_0000);
        check4("reset_stat", prog_stat, STAT_AOK);
        @(negedge clk);
        rst = 1'b0;

        // combinational RUN vectors (none of these load the ret counter or change state)
        for (int i = 0; i < 10; i++) begin
            D_icode = vecs[i].d_icode; d_srcA = vecs[i].srca; d_srcB = vecs[i].srcb;
            E_icode = vecs[i].e_icode; E_dstM = vecs[i].e_dstm; e_Cnd = vecs[i].cnd;
            #1;
            check8(vecs[i].name, outs(), vecs[i].exp);
            next_cycle();
        end

        // ret: one cycle in D, then F_stall/D_bubble for exactly 3 cycles
        set_idle();
        D_icode = IRET;
        #1 check8("ret_c0", outs(), 8'b1010_0000);
        next_cycle();
        D_icode = INOP;
        for (int c = 1; c < 4; c++) begin
            #1 check8($sformatf("ret_c%0d", c), outs(), (c < 3) ? 8'b1010_0000 : 8'b0000_0000);
            next_cycle();
        end

        // ret blocked by load/use in its first cycle; loads only once lu clears
        D_icode = IRET; E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
        #1 check8("retlu_c0", outs(), 8'b1101_0000);
        next_cycle();
        E_icode = INOP; E_dstM = RNONE; d_srcA = RNONE;
        #1 check8("retlu_c1", outs(), 8'b1010_0000);
        next_cycle();
        D_icode = INOP;
        for (int c = 2; c < 5; c++) begin
            #1 check8($sformatf("retlu_c%0d", c), outs(), (c < 4) ? 8'b1010_0000 : 8'b0000_0000);
            next_cycle();
        end

        // mispredict with ret in D: ret squashed, no counter load
        D_icode = IRET; E_icode = IJXX; e_Cnd = 1'b0;
        #1 check8("retmp_c0", outs(), 8'b1011_0000);
        next_cycle();
        set_idle();
        #1 check8("retmp_c1", outs(), 8'b0000_0000);
        next_cycle();

        // exception drain: M fault, then W fault, then frozen
        E_icode = IOPQ; m_stat = STAT_ADR;
        #1 check8("drain_run", outs(), 8'b0000_1000);
        next_cycle();
        m_stat = STAT_AOK; W_stat = STAT_ADR;
        #1 check8("drain_st", outs(), 8'b1011_1000);
        next_cycle();
        W_stat = STAT_AOK;
        #1 check8("halt_outs", outs(), 8'b1100_0101);
        check4("halt_stat", prog_stat, STAT_ADR);
        W_stat = STAT_HLT; m_stat = STAT_INS; D_icode = IRET;
        repeat (3) next_cycle();
        #1 check8("halt_hold", outs(), 8'b1100_0101);
        check4("halt_stat_once", prog_stat, STAT_ADR);

        // async reset from HALTED, no clock edge required
        #2 rst = 1'b1;
        set_idle();
        #1 check8("rst_async_outs", outs(), 8'b0000_0000);
        check4("rst_async_stat", prog_stat, STAT_AOK);
        next_cycle();
        rst = 1'b0;

        // halt directly from RUN
        W_stat = STAT_HLT;
        #1 check8("hlt_run", outs(), 8'b0000_1100);
        next_cycle();
        W_stat = STAT_AOK;
        #1 check8("hlt_frozen", outs(), 8'b1100_0101);
        check4("hlt_stat", prog_stat, STAT_HLT);
        do_reset();

        // both faults in one cycle go straight to HALTED with W status
        m_stat = STAT_ADR; W_stat = STAT_INS;
        next_cycle();
        set_idle();
        #1 check8("dual_fault", outs(), 8'b1100_0101);
        check4("dual_stat", prog_stat, STAT_INS);
        do_reset();

        // reset mid-ret clears the counter
        D_icode = IRET;
        next_cycle();
        D_icode = INOP;
        #1 check8("midret_busy", outs(), 8'b1010_0000);
        #2 rst = 1'b1;
        #1 check8("midret_rst", outs(), 8'b0000_0000);
        next_cycle();
        rst = 1'b0;
        #1 check8("midret_after", outs(), 8'b0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
